fb_write_sched: RTL

FB_WRITE_SCHED -- requirements
Module: fb_write_sched

---
 rtl/fb_write_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fb_write_sched.sv
// Frame-buffer write scheduler: round-robin arbitration of two pixel
// writers plus a vsync-aligned full-buffer clear engine.
module fb_write_sched #(
    parameter int AW      = 15,
    parameter int DW      = 3,
    parameter int FB_SIZE = 19200
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync_n,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          frame_tick,
    output logic          busy,
    output logic          clr_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [AW-1:0] LAST = AW'(FB_SIZE - 1);

    state_t        state_q;
    logic          vs_q;
    logic          clr_pend_q;
    logic [DW-1:0] color_q;
    logic [AW-1:0] cnt_q;
    logic          last_b_q;
    logic          gnt_a_q;
    logic          gnt_b_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          we_q;
    logic          tick_q;
    logic          busy_q;
    logic          done_q;

    logic vs_fall;
    logic go_clr;
    logic last_clr;
    logic clr_pend_d;
    logic in_clr_d;
    logic elig_a;
    logic elig_b;
    logic pick_b;

    always_comb begin
        vs_fall    = vs_q & ~vsync_n;
        go_clr     = (state_q == IDLE) & clr_pend_q & vs_fall;
        last_clr   = (state_q == CLEAR) & (cnt_q == LAST);
        clr_pend_d = clr_start | (clr_pend_q & ~go_clr);
        in_clr_d   = go_clr | ((state_q == CLEAR) & ~last_clr);
        elig_a     = req_a & ~gnt_a_q;
        elig_b     = req_b & ~gnt_b_q;
        // On a tie the requester not served last wins.
        pick_b     = elig_b & (~elig_a | ~last_b_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            vs_q       <= 1'b1;
            clr_pend_q <= 1'b0;
            color_q    <= '0;
            cnt_q      <= '0;
            last_b_q   <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            vs_q       <= vsync_n;
            tick_q     <= vs_fall;
            clr_pend_q <= clr_pend_d;
            busy_q     <= clr_pend_d | in_clr_d;
            if (clr_start) begin
                color_q <= clr_color;
            end
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go_clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        data_q  <= color_q;
                        we_q    <= 1'b1;
                    end else if (elig_a | elig_b) begin
                        we_q     <= 1'b1;
                        last_b_q <= pick_b;
                        gnt_a_q  <= ~pick_b;
                        gnt_b_q  <= pick_b;
                        addr_q   <= pick_b ? addr_b : addr_a;
                        data_q   <= pick_b ? data_b : data_a;
                    end
                end
                CLEAR: begin
                    if (last_clr) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        addr_q <= cnt_q + 1'b1;
                        data_q <= color_q;
                        we_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign mem_we     = we_q;
    assign frame_tick = tick_q;
    assign busy       = busy_q;
    assign clr_done   = done_q;

endmodule
